// File: rtl/uart_pkg.sv
// Shared UART definitions: default line/clock constants, state encodings and
// a small width helper used by the receiver, transmitter and baud generator.
package uart_pkg;

    localparam int DEFAULT_CLK_SPEED   = 100_000_000;
    localparam int DEFAULT_SERIAL_COMM = 115_200;
    localparam int DEFAULT_OVS         = 16;
    localparam int DATA_BITS           = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    // Counter width for a modulo-n counter; never returns zero.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/baud_gen.sv
// Free-running tick generator: pulses tick_o once every CLK_SPEED/TICK_RATE
// clocks; clear_i holds the count at zero and suppresses the tick.
module baud_gen
    import uart_pkg::*;
#(
    parameter int CLK_SPEED = DEFAULT_CLK_SPEED,
    parameter int TICK_RATE = DEFAULT_SERIAL_COMM * DEFAULT_OVS
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    output logic tick_o
);

    localparam int TICK  = CLK_SPEED / TICK_RATE;
    localparam int CNT_W = cnt_width(TICK);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        // NOTE: every signal written here gets a value first, so no path can leave it unassigned and infer a latch.
        cnt_d = cnt_q + CNT_W'(1);
        if (clear_i || (cnt_q == CNT_MAX)) begin
            cnt_d = '0;
        end
    end

    assign tick_o = !clear_i && (cnt_q == CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises rx, oversamples with baud_gen ticks and
// centre-samples each bit; reports good frames and stop-bit errors as pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_SPEED   = DEFAULT_CLK_SPEED,
    parameter int SERIAL_COMM = DEFAULT_SERIAL_COMM,
    parameter int OVS         = DEFAULT_OVS
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int OS_W = cnt_width(OVS);
    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVS - 1);
    localparam logic [OS_W-1:0] OS_HALF = OS_W'(OVS / 2 - 1);

    logic [1:0]           sync_q;
    logic                 rx_s;
    logic                 s_tick;
    logic                 baud_clear;

    uart_state_e          state_q,      state_d;
    logic [OS_W-1:0]      os_cnt_q,     os_cnt_d;
    logic [2:0]           bit_idx_q,    bit_idx_d;
    logic [DATA_BITS-1:0] shift_q,      shift_d;
    logic [DATA_BITS-1:0] data_out_q,   data_out_d;
    logic                 data_valid_q, data_valid_d;
    logic                 frame_err_q,  frame_err_d;
    logic                 err_wait_q,   err_wait_d;

    assign rx_s       = sync_q[1];
    assign baud_clear = (state_q == IDLE) || !en;

    baud_gen #(
        .CLK_SPEED (CLK_SPEED),
        .TICK_RATE (SERIAL_COMM * OVS)
    ) u_baud_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (baud_clear),
        .tick_o  (s_tick)
    );

    always_comb begin
        state_d      = state_q;
        os_cnt_d     = os_cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        err_wait_d   = err_wait_q;

        if (!en) begin
            state_d    = IDLE;
            os_cnt_d   = '0;
            bit_idx_d  = '0;
            err_wait_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    err_wait_d = 1'b0;
                    if (!rx_s) begin
                        state_d   = START;
                        os_cnt_d  = '0;
                        bit_idx_d = '0;
                    end
                end
                START: begin
                    if (s_tick) begin
                        if (os_cnt_q == OS_HALF) begin
                            os_cnt_d = '0;
                            state_d  = rx_s ? IDLE : DATA;
                        end else begin
                            os_cnt_d = os_cnt_q + OS_W'(1);
                        end
                    end
                end
                DATA: begin
                    if (s_tick) begin
                        if (os_cnt_q == OS_LAST) begin
                            os_cnt_d  = '0;
                            shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
                            bit_idx_d = bit_idx_q + 3'd1;
                            if (bit_idx_q == 3'd7) begin
                                state_d = STOP;
                            end
                        end else begin
                            os_cnt_d = os_cnt_q + OS_W'(1);
                        end
                    end
                end
                STOP: begin
                    // After a low stop bit, sit here until the line idles again.
                    if (err_wait_q) begin
                        if (rx_s) begin
                            state_d    = IDLE;
                            err_wait_d = 1'b0;
                        end
                    end else if (s_tick) begin
                        if (os_cnt_q == OS_LAST) begin
                            os_cnt_d   = '0;
                            data_out_d = shift_q;
                            if (rx_s) begin
                                data_valid_d = 1'b1;
                                state_d      = IDLE;
                            end else begin
                                frame_err_d = 1'b1;
                                err_wait_d  = 1'b1;
                            end
                        end else begin
                            os_cnt_d = os_cnt_q + OS_W'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q       <= 2'b11;
            state_q      <= IDLE;
            os_cnt_q     <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            err_wait_q   <= 1'b0;
        end else begin
            sync_q       <= {sync_q[0], rx};
            state_q      <= state_d;
            os_cnt_q     <= os_cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            frame_err_q  <= frame_err_d;
            err_wait_q   <= err_wait_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign frame_err  = frame_err_q;
    assign rx_busy    = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: drives 8N1 frames at the real line rate and
// compares observed pulses against frame-level expectations.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int CLK_SPEED   = 100_000_000;
    localparam int SERIAL_COMM = 115_200;
    localparam int OVS         = 16;
    localparam int TICK        = CLK_SPEED / (SERIAL_COMM * OVS);
    localparam int BIT_CLKS    = CLK_SPEED / SERIAL_COMM;
    localparam int DV_LAT      = (TICK * OVS * 19) / 2;
    localparam int LAT_TOL     = 60;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b1;
    logic       rx = 1'b1;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       rx_busy;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
        int         cyc;
    } evt_t;

    evt_t obs_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    bit   dv_prev = 1'b0;
    bit   fe_prev = 1'b0;

    uart_rx #(
        .CLK_SPEED   (CLK_SPEED),
        .SERIAL_COMM (SERIAL_COMM),
        .OVS         (OVS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .rx         (rx),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .rx_busy    (rx_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor: records every output pulse and checks exclusivity and width.
    always @(negedge clk) begin
        if (data_valid === 1'b1 || frame_err === 1'b1) begin
            n_checks++;
            if ((data_valid && frame_err) || (data_valid && dv_prev) || (frame_err && fe_prev)) begin
                n_fail++;
                $display("FAIL pulse_shape: got dv=%0b fe=%0b prev_dv=%0b prev_fe=%0b, required single exclusive pulse",
                         data_valid, frame_err, dv_prev, fe_prev);
            end
            obs_q.push_back('{is_err: frame_err, data: data_out, cyc: cyc});
        end
        dv_prev = data_valid;
        fe_prev = frame_err;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Drives one complete frame; entered and left on a falling clock edge.
    task automatic send_frame(input logic [7:0] b, input bit stop, output int start_cyc);
        rx = 1'b0;
        start_cyc = cyc;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
        rx = stop;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en    = 1'b1;
        rx    = 1'b1;
        repeat (5) @(negedge clk);
        n_checks++;
        if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data_out: got %0h required 00", data_out); end
        n_checks++;
        if (data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_data_valid: got %0b required 0", data_valid); end
        n_checks++;
        if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %0b required 0", frame_err); end
        n_checks++;
        if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_rx_busy: got %0b required 0", rx_busy); end
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        n_checks++;
        if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle: got busy=%0b required 0", rx_busy); end
    endtask

    task automatic test_single_a5();
        int s;
        int lat;
        obs_q.delete();
        send_frame(8'hA5, 1'b1, s);
        repeat (10) @(negedge clk);
        n_checks++;
        if (obs_q.size() !== 1) begin
            n_fail++; $display("FAIL a5_count: got %0d pulses required 1", obs_q.size());
        end else begin
            lat = obs_q[0].cyc - s;
            n_checks++;
            if (obs_q[0].is_err !== 1'b0 || obs_q[0].data !== 8'hA5) begin
                n_fail++; $display("FAIL a5_frame: got err=%0b data=%0h required err=0 data=a5", obs_q[0].is_err, obs_q[0].data);
            end
            n_checks++;
            if (lat < DV_LAT - LAT_TOL || lat > DV_LAT + LAT_TOL) begin
                n_fail++; $display("FAIL a5_latency: got %0d clks required %0d +/- %0d", lat, DV_LAT, LAT_TOL);
            end
        end
        n_checks++;
        if (data_out !== 8'hA5 || rx_busy !== 1'b0) begin
            n_fail++; $display("FAIL a5_outputs: got data_out=%0h busy=%0b required a5/0", data_out, rx_busy);
        end
    endtask

    task automatic test_random_frames();
        for (int k = 0; k < 2; k++) begin
            logic [7:0] b;
            bit         stop;
            int         s;
            b    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            obs_q.delete();
            send_frame(b, stop, s);
            if (!stop) begin
                repeat (BIT_CLKS) @(negedge clk);
                rx = 1'b1;
            end
            repeat ($urandom_range(10, 300)) @(negedge clk);
            n_checks++;
            if (obs_q.size() !== 1) begin
                n_fail++; $display("FAIL rand_count[%0d]: got %0d pulses required 1", k, obs_q.size());
            end else if (obs_q[0].is_err !== !stop || obs_q[0].data !== b) begin
                n_fail++; $display("FAIL rand_frame[%0d]: got err=%0b data=%0h required err=%0b data=%0h",
                                   k, obs_q[0].is_err, obs_q[0].data, !stop, b);
            end
            n_checks++;
            if (data_out !== b || rx_busy !== 1'b0) begin
                n_fail++; $display("FAIL rand_hold[%0d]: got data_out=%0h busy=%0b required %0h/0", k, data_out, rx_busy, b);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [2];
        int s;
        bytes[0] = 8'h00;
        bytes[1] = 8'hFF;
        obs_q.delete();
        for (int i = 0; i < 2; i++) send_frame(bytes[i], 1'b1, s);
        repeat (10) @(negedge clk);
        n_checks++;
        if (obs_q.size() !== 2) begin
            n_fail++; $display("FAIL b2b_count: got %0d pulses required 2", obs_q.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (obs_q[i].is_err !== 1'b0 || obs_q[i].data !== bytes[i]) begin
                    n_fail++; $display("FAIL b2b_frame[%0d]: got err=%0b data=%0h required err=0 data=%0h",
                                       i, obs_q[i].is_err, obs_q[i].data, bytes[i]);
                end
            end
        end
    endtask

    task automatic test_glitch();
        logic [7:0] prev;
        bit         busy_seen;
        bit         dropped;
        prev      = data_out;
        busy_seen = 1'b0;
        dropped   = 1'b0;
        obs_q.delete();
        rx = 1'b0;
        repeat (200) begin
            @(negedge clk);
            if (rx_busy) busy_seen = 1'b1;
        end
        rx = 1'b1;
        for (int i = 0; i < 2000 && !dropped; i++) begin
            @(negedge clk);
            if (!rx_busy) dropped = 1'b1;
        end
        repeat (BIT_CLKS) @(negedge clk);
        n_checks++;
        if (!busy_seen) begin n_fail++; $display("FAIL glitch_busy_rise: got busy never high required high"); end
        n_checks++;
        if (!dropped || rx_busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_fall: got busy=%0b required 0", rx_busy); end
        n_checks++;
        if (obs_q.size() !== 0 || data_out !== prev) begin
            n_fail++; $display("FAIL glitch_no_pulse: got %0d pulses data_out=%0h required 0/%0h", obs_q.size(), data_out, prev);
        end
    endtask

    task automatic test_frame_error();
        int s;
        obs_q.delete();
        send_frame(8'h3C, 1'b0, s);
        repeat (2 * BIT_CLKS - 5) @(negedge clk);
        n_checks++;
        if (rx_busy !== 1'b1) begin n_fail++; $display("FAIL ferr_busy_hold: got %0b required 1", rx_busy); end
        repeat (5) @(negedge clk);
        rx = 1'b1;
        repeat (6) @(negedge clk);
        n_checks++;
        if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL ferr_busy_fall: got %0b required 0", rx_busy); end
        n_checks++;
        if (obs_q.size() !== 1) begin
            n_fail++; $display("FAIL ferr_count: got %0d pulses required 1", obs_q.size());
        end else if (obs_q[0].is_err !== 1'b1 || obs_q[0].data !== 8'h3C) begin
            n_fail++; $display("FAIL ferr_frame: got err=%0b data=%0h required err=1 data=3c", obs_q[0].is_err, obs_q[0].data);
        end
        n_checks++;
        if (data_out !== 8'h3C) begin n_fail++; $display("FAIL ferr_data_out: got %0h required 3c", data_out); end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] b;
        int s;
        b = 8'h5A;
        obs_q.delete();
        rx = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
        rx = b[4];
        repeat (BIT_CLKS / 2) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (rx_busy !== 1'b0 || data_out !== 8'h00) begin
            n_fail++; $display("FAIL rst_mid_state: got busy=%0b data_out=%0h required 0/00", rx_busy, data_out);
        end
        rx = 1'b1;
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        n_checks++;
        if (obs_q.size() !== 0 || rx_busy !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_no_pulse: got %0d pulses busy=%0b required 0/0", obs_q.size(), rx_busy);
        end
        send_frame(8'h81, 1'b1, s);
        repeat (10) @(negedge clk);
        n_checks++;
        if (obs_q.size() !== 1 || data_out !== 8'h81) begin
            n_fail++; $display("FAIL rst_mid_next: got %0d pulses data_out=%0h required 1/81", obs_q.size(), data_out);
        end else if (obs_q[0].is_err !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_kind: got frame_err required data_valid");
        end
    endtask

    task automatic test_enable_drop();
        logic [7:0] prev;
        logic [7:0] b;
        int s;
        prev = data_out;
        b    = 8'($urandom);
        obs_q.delete();
        rx = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx = b[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
        n_checks++;
        if (rx_busy !== 1'b1) begin n_fail++; $display("FAIL en_busy_before: got %0b required 1", rx_busy); end
        en = 1'b0;
        @(negedge clk);
        n_checks++;
        if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL en_busy_drop: got %0b required 0", rx_busy); end
        rx = 1'b1;
        repeat (200) @(negedge clk);
        n_checks++;
        if (obs_q.size() !== 0 || data_out !== prev) begin
            n_fail++; $display("FAIL en_retain: got %0d pulses data_out=%0h required 0/%0h", obs_q.size(), data_out, prev);
        end
        en = 1'b1;
        repeat (20) @(negedge clk);
        send_frame(8'h7E, 1'b1, s);
        repeat (10) @(negedge clk);
        n_checks++;
        if (obs_q.size() !== 1 || data_out !== 8'h7E) begin
            n_fail++; $display("FAIL en_next_frame: got %0d pulses data_out=%0h required 1/7e", obs_q.size(), data_out);
        end
    endtask

    initial begin
        test_reset();
        test_single_a5();
        test_random_frames();
        test_back_to_back();
        test_glitch();
        test_frame_error();
        test_reset_mid_frame();
        test_enable_drop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
